if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the single-issue RISC-V pipeline.
- Owns the program counter. Drives the PC to instruction memory and to the external PC+4 adder, then takes the adder result back as the sequential next PC.
- Selects the next PC from the sequential path, a branch/jump redirect, or a trap vector.
- Registers the fetched instruction into the IF/ID pipeline register with a valid bit, and counts valid fetches.

---
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, selects the next PC from
//               sequential / redirect / trap sources, and fills IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_inc,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_misalign_trap;
    logic [31:0] r_misalign_addr;
    logic [31:0] r_fetch_count;

    logic        w_misalign;
    logic        w_latch;
    logic [31:0] w_pc_next;

    assign w_misalign = pc_src && (branch_target[1:0] != 2'b00);

    // A redirect or flush kills the slot even under stall; only a clean,
    // unstalled edge captures a new instruction.
    assign w_latch = !flush && !pc_src && !stall;

    always_comb begin
        w_pc_next = pc_inc;
        if (w_misalign) begin
            w_pc_next = TRAP_VECTOR;
        end else if (pc_src) begin
            w_pc_next = branch_target;
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_if_id_pc      <= 32'h0;
            r_if_id_instr   <= 32'h0;
            r_if_id_valid   <= 1'b0;
            r_misalign_trap <= 1'b0;
            r_misalign_addr <= 32'h0;
            r_fetch_count   <= 32'h0;
        end else begin
            r_pc            <= w_pc_next;
            r_misalign_trap <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= branch_target;
            end
            if (flush || pc_src) begin
                r_if_id_valid <= 1'b0;
            end else if (w_latch) begin
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= imem_instr;
                r_if_id_valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign pc_out        = r_pc;
    assign if_id_pc      = r_if_id_pc;
    assign if_id_instr   = r_if_id_instr;
    assign if_id_valid   = r_if_id_valid;
    assign misalign_trap = r_misalign_trap;
    assign misalign_addr = r_misalign_addr;
    assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed and randomized checks of if_fetch_stage against a
//               behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, pc_src;
    logic [31:0] branch_target, pc_inc, imem_instr;
    logic [31:0] pc_out, if_id_pc, if_id_instr, misalign_addr, fetch_count;
    logic        if_id_valid, misalign_trap;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the architectural state
    logic [31:0] m_pc, m_ipc, m_instr, m_maddr, m_cnt;
    logic        m_valid, m_trap;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc_inc        (pc_inc),
        .imem_instr    (imem_instr),
        .pc_out        (pc_out),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .misalign_trap (misalign_trap),
        .misalign_addr (misalign_addr),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    // One clock: apply inputs, advance the model by the fetch rules, settle.
    task automatic cycle(input logic rst, input logic stl, input logic fl,
                         input logic src, input logic [31:0] tgt,
                         input logic use_inc, input logic [31:0] inc);
        logic mis;
        reset = rst; stall = stl; flush = fl; pc_src = src; branch_target = tgt;
        pc_inc     = use_inc ? inc : m_pc + 32'd4;
        imem_instr = instr_at(m_pc);
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_trap = 1'b0; m_maddr = 32'h0; m_cnt = 32'h0;
        end else begin
            mis    = src && (tgt % 4 != 0);
            m_trap = mis;
            if (mis) m_maddr = tgt;
            if (fl || src) begin
                m_valid = 1'b0;
            end else if (!stl) begin
                m_ipc = m_pc; m_instr = instr_at(m_pc); m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            if (mis)      m_pc = 32'h100;
            else if (src) m_pc = tgt;
            else if (!stl) m_pc = pc_inc;
        end
        #1;
    endtask

    task automatic test_reset();
        m_pc = 32'hDEAD_BEEF;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 32'h42, 1, 32'h1234);
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h required=%h", pc_out, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", if_id_valid); end
        checks++; if (misalign_trap !== 1'b0 || misalign_addr !== 32'h0) begin failures++; $display("FAIL reset_trap actual=%b/%h required=0/0", misalign_trap, misalign_addr); end
        checks++; if (fetch_count !== 32'h0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin failures++; $display("FAIL reset_ifid actual=%h/%h/%h required=0/0/0", fetch_count, if_id_pc, if_id_instr); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            checks++; if (pc_out !== 32'(4 * i)) begin failures++; $display("FAIL run_pc%0d actual=%h required=%h", i, pc_out, 32'(4 * i)); end
            checks++; if (if_id_pc !== 32'(4 * (i - 1)) || if_id_valid !== 1'b1) begin failures++; $display("FAIL run_ifid%0d actual=%h/%b required=%h/1", i, if_id_pc, if_id_valid, 32'(4 * (i - 1))); end
        end
        checks++; if (fetch_count !== 32'd3 || if_id_instr !== instr_at(32'h8)) begin failures++; $display("FAIL run_count actual=%0d/%h required=3/%h", fetch_count, if_id_instr, instr_at(32'h8)); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            checks++; if (pc_out !== 32'hC || if_id_pc !== 32'h8 || if_id_valid !== 1'b1 || fetch_count !== 32'd3) begin
                failures++; $display("FAIL stall_hold actual=%h/%h/%b/%0d required=c/8/1/3", pc_out, if_id_pc, if_id_valid, fetch_count); end
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc_out !== 32'h10 || if_id_pc !== 32'hC || fetch_count !== 32'd4) begin failures++; $display("FAIL stall_release actual=%h/%h/%0d required=10/c/4", pc_out, if_id_pc, fetch_count); end
    endtask

    task automatic test_redirect();
        cycle(0, 1, 0, 1, 32'h40, 0, 0);
        checks++; if (pc_out !== 32'h40 || if_id_valid !== 1'b0 || if_id_pc !== 32'hC) begin failures++; $display("FAIL redir_pc actual=%h/%b/%h required=40/0/c", pc_out, if_id_valid, if_id_pc); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || pc_out !== 32'h44) begin failures++; $display("FAIL redir_ifid actual=%h/%b/%h required=40/1/44", if_id_pc, if_id_valid, pc_out); end
    endtask

    task automatic test_misalign();
        cycle(0, 0, 0, 1, 32'h42, 0, 0);
        checks++; if (pc_out !== 32'h100 || misalign_trap !== 1'b1 || misalign_addr !== 32'h42 || if_id_valid !== 1'b0) begin
            failures++; $display("FAIL mis_take actual=%h/%b/%h/%b required=100/1/42/0", pc_out, misalign_trap, misalign_addr, if_id_valid); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++; if (misalign_trap !== 1'b0 || misalign_addr !== 32'h42 || if_id_pc !== 32'h100) begin failures++; $display("FAIL mis_pulse actual=%b/%h/%h required=0/42/100", misalign_trap, misalign_addr, if_id_pc); end
    endtask

    task automatic test_flush_stall();
        logic [31:0] pc0;
        pc0 = m_pc;
        cycle(0, 1, 1, 0, 0, 0, 0);
        checks++; if (if_id_valid !== 1'b0 || pc_out !== pc0) begin failures++; $display("FAIL flush_stall actual=%b/%h required=0/%h", if_id_valid, pc_out, pc0); end
    endtask

    task automatic test_mid_reset();
        cycle(0, 0, 0, 1, 32'h1C, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc_out !== 32'h20) begin failures++; $display("FAIL mid_setup actual=%h required=20", pc_out); end
        cycle(1, 0, 0, 0, 0, 0, 0);
        checks++; if (pc_out !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin failures++; $display("FAIL mid_reset actual=%h/%b/%0d required=0/0/0", pc_out, if_id_valid, fetch_count); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc_out !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1) begin failures++; $display("FAIL wrap actual=%h/%h/%b required=0/fffffffc/1", pc_out, if_id_pc, if_id_valid); end
    endtask

    task automatic test_random();
        logic [31:0] tgt, inc;
        logic        rst, stl, fl, src, use_inc;
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            stl     = ($urandom_range(0, 3) == 0);
            fl      = ($urandom_range(0, 5) == 0);
            src     = ($urandom_range(0, 5) == 0);
            tgt     = $urandom;
            if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
            use_inc = ($urandom_range(0, 9) == 0);
            inc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            cycle(rst, stl, fl, src, tgt, use_inc, inc);
            checks++;
            if (pc_out !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_instr || if_id_valid !== m_valid ||
                misalign_trap !== m_trap || misalign_addr !== m_maddr || fetch_count !== m_cnt) begin
                failures++;
                $display("FAIL rand%0d actual=%h %h %h %b %b %h %0d required=%h %h %h %b %b %h %0d", i,
                         pc_out, if_id_pc, if_id_instr, if_id_valid, misalign_trap, misalign_addr, fetch_count,
                         m_pc, m_ipc, m_instr, m_valid, m_trap, m_maddr, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
        branch_target = 32'h0; pc_inc = 32'h0; imem_instr = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_misalign();
        test_flush_stall();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
